// File: rtl/adder_pipe_nbit.sv
// Pipelined WIDTH-bit adder/subtractor: each stage adds one CHUNK and registers its carry,
// with a valid/ready handshake and per-stage backpressure so bubbles collapse.
`timescale 1ns/1ps
module adder_pipe_nbit #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   S,
    output logic             OVF
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("adder_pipe_nbit: WIDTH=%0d must be >= 2 and a multiple of STAGES=%0d", WIDTH, STAGES);
    end

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];

    logic [STAGES-1:0] ready;
    logic [STAGES-1:0] v_src;
    logic [STAGES-1:0] c_src;
    logic [WIDTH-1:0]  a_src [STAGES];
    logic [WIDTH-1:0]  b_src [STAGES];
    logic [WIDTH-1:0]  s_src [STAGES];
    logic [WIDTH-1:0]  s_d   [STAGES];
    logic [CHUNK:0]    chunk_sum [STAGES];

    function automatic logic [STAGES-1:0] low_mask(input int n);
        logic [STAGES-1:0] m;
        m = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Stage k can load unless it and every stage after it are full while the sink stalls.
    // Written as a flat tail check rather than a ready chain to keep the logic acyclic.
    always_comb begin
        ready = '0;
        for (int k = 0; k < STAGES; k++) begin
            ready[k] = out_ready || ((valid_q | low_mask(k)) != '1);
        end
    end

    assign in_ready = ready[0];

    always_comb begin
        a_src[0] = A;
        b_src[0] = SUB ? ~B : B;
        s_src[0] = '0;
        c_src[0] = SUB ? ~Cin : Cin;
        v_src[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            s_src[k] = s_q[k-1];
            c_src[k] = carry_q[k-1];
            v_src[k] = valid_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            chunk_sum[k] = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
                         + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
                         + (CHUNK+1)'(c_src[k]);
            s_d[k] = s_src[k];
            s_d[k][k*CHUNK +: CHUNK] = chunk_sum[k][CHUNK-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ready[k]) begin
                    valid_q[k] <= v_src[k];
                    // Data only moves with a valid token, so bubbles leave the registers untouched.
                    if (v_src[k]) begin
                        a_q[k]     <= a_src[k];
                        b_q[k]     <= b_src[k];
                        s_q[k]     <= s_d[k];
                        carry_q[k] <= chunk_sum[k][CHUNK];
                    end
                end
            end
        end
    end

    assign out_valid = valid_q[LAST];
    assign S         = {carry_q[LAST], s_q[LAST]};
    // b_q already holds the effective (possibly inverted) operand.
    assign OVF       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                    && (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule
